// File: rtl/fft_uart_packer.sv
// fft_uart_packer: buffers one frame of complex FFT results and streams it out
// byte by byte to a UART transmitter: two header bytes, then for every sample
// re[15:8], re[7:0], im[15:8], im[7:0].
module fft_uart_packer #(
    parameter int          N_POINTS = 128,
    parameter int          DATA_W   = 16,
    parameter logic [7:0]  HDR0     = 8'hA5,
    parameter logic [7:0]  HDR1     = 8'h5A
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              busy,
    output logic              frame_done
);

    localparam int AW          = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam int FRAME_BYTES = 4 * N_POINTS + 2;
    localparam int BW          = $clog2(FRAME_BYTES);
    localparam int WORD_W      = 2 * DATA_W;

    localparam logic [AW-1:0] LAST_SAMPLE = AW'(N_POINTS - 1);
    localparam logic [BW-1:0] LAST_BYTE   = BW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              frame_done_q, frame_done_d;

    // Frame buffer, word = {re, im}; contents survive reset on purpose.
    logic [WORD_W-1:0] mem [N_POINTS];
    logic [WORD_W-1:0] rd_data_q;
    logic              wr_en;
    logic [AW-1:0]     rd_addr;
    logic [1:0]        cur_sel;
    logic [7:0]        cur_byte;

    // Read address follows the *next* byte counter so the word is already
    // registered by the time ISSUE needs it (one-cycle read latency hidden).
    always_comb begin
        rd_addr  = AW'((byte_cnt_d - BW'(2)) >> 2);
        cur_sel  = 2'(byte_cnt_q - BW'(2));
        cur_byte = 8'h00;
        if (byte_cnt_q == BW'(0)) begin
            cur_byte = HDR0;
        end else if (byte_cnt_q == BW'(1)) begin
            cur_byte = HDR1;
        end else begin
            case (cur_sel)
                2'd0:    cur_byte = rd_data_q[WORD_W-1 -: 8];
                2'd1:    cur_byte = rd_data_q[WORD_W-9 -: 8];
                2'd2:    cur_byte = rd_data_q[DATA_W-1 -: 8];
                default: cur_byte = rd_data_q[DATA_W-9 -: 8];
            endcase
        end
    end

    // Next-state and output decode for the fill / issue / wait / done sequence.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        wr_en        = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        sample_cnt_d = '0;
                        byte_cnt_d   = '0;
                        state_d      = ISSUE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + AW'(1);
                    end
                end
            end
            ISSUE: begin
                // Never start a byte while the transmitter is still shifting.
                if (!tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = cur_byte;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                        state_d    = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
        frame_done_d = (state_d == DONE);
    end

    // State, counters and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= FILL;
            sample_cnt_q <= '0;
            byte_cnt_q   <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Block RAM: write on the accepting edge, registered read every cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[sample_cnt_q] <= {in_re, in_im};
        end
        rd_data_q <= mem[rd_addr];
    end

    assign in_ready   = (state_q == FILL);
    assign busy       = (state_q != FILL);
    assign tx_dv      = tx_dv_q;
    assign tx_byte    = tx_byte_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_uart_packer.sv
// Testbench for fft_uart_packer: behavioural UART_TX responder, expected byte
// queue filled by the stimulus, independent monitor popping on every tx_dv.
module tb_fft_uart_packer;

    localparam int N           = 128;
    localparam int FRAME_BYTES = 4 * N + 2;

    logic        clk;
    logic        rstb;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic        busy;
    logic        frame_done;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    int          dv_in_frame = 0;
    int          frames_seen = 0;
    logic [7:0]  last_byte;
    logic        dv_prev;
    logic        fd_prev;
    int          uart_cnt;

    fft_uart_packer #(
        .N_POINTS(N),
        .DATA_W  (16),
        .HDR0    (8'hA5),
        .HDR1    (8'h5A)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART_TX stand-in: active for 6 cycles, done pulses mid-way and active
    // lingers one cycle past done so the packer has to wait in ISSUE.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            uart_cnt  <= 0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_active) begin
                if (tx_dv) begin
                    tx_active <= 1'b1;
                    uart_cnt  <= 6;
                end
            end else begin
                uart_cnt <= uart_cnt - 1;
                if (uart_cnt == 3) tx_done   <= 1'b1;
                if (uart_cnt == 1) tx_active <= 1'b0;
            end
        end
    end

    // Monitor: compares every issued byte and frame-level protocol properties.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstb) begin
                dv_in_frame = 0;
                dv_prev     = 1'b0;
                fd_prev     = 1'b0;
            end else begin
                if (tx_dv) begin
                    check("tx_dv_while_active", tx_active, 1'b0);
                    check("tx_dv_width", dv_prev, 1'b0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %02h expected none", tx_byte);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("tx_byte", tx_byte, e);
                    end
                    last_byte = tx_byte;
                    dv_in_frame++;
                end
                if (tx_done) check("tx_byte_hold", tx_byte, last_byte);
                if (frame_done) begin
                    frames_seen++;
                    check("frame_done_width", fd_prev, 1'b0);
                    check("dv_per_frame", dv_in_frame, FRAME_BYTES);
                    $display("frame %0d done: %0d bytes issued", frames_seen, dv_in_frame);
                    dv_in_frame = 0;
                end
                dv_prev = tx_dv;
                fd_prev = frame_done;
            end
        end
    end

    // Feed one frame (mode 0 ramp, mode 1 constant) and queue its byte stream.
    task automatic feed_frame(input int mode, input bit throttle);
        logic [15:0] re;
        logic [15:0] im;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < N; i++) begin
            re = (mode == 0) ? 16'(i) : 16'h8000;
            im = (mode == 0) ? ~16'(i) : 16'h7FFF;
            exp_q.push_back(re[15:8]);
            exp_q.push_back(re[7:0]);
            exp_q.push_back(im[15:8]);
            exp_q.push_back(im[7:0]);
        end
        for (int i = 0; i < N; i++) begin
            re = (mode == 0) ? 16'(i) : 16'h8000;
            im = (mode == 0) ? ~16'(i) : 16'h7FFF;
            if (throttle) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_re    = 16'($urandom);
                    @(posedge clk); #1;
                    check("in_ready_idle_fill", in_ready, 1'b1);
                end
            end
            in_valid = 1'b1;
            in_re    = re;
            in_im    = im;
            check("in_ready_fill", in_ready, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("in_ready_after_fill", in_ready, 1'b0);
        check("busy_after_fill", busy, 1'b1);
        check("tx_dv_in_issue", tx_dv, 1'b0);
        @(posedge clk); #1;
        check("first_tx_dv", tx_dv, 1'b1);
    endtask

    // Wait for frame_done (bounded); optionally push junk samples meanwhile.
    task automatic wait_frame(input bit junk);
        bit seen = 1'b0;
        if (junk) in_valid = 1'b1;
        for (int c = 0; c < 20000 && !seen; c++) begin
            if (junk) begin
                in_re = 16'($urandom);
                in_im = 16'($urandom);
            end
            @(posedge clk); #1;
            if (frame_done) begin
                in_valid = 1'b0;
                seen     = 1'b1;
                check("in_ready_at_frame_done", in_ready, 1'b0);
                check("busy_at_frame_done", busy, 1'b1);
                @(posedge clk); #1;
                check("in_ready_after_done", in_ready, 1'b1);
                check("busy_after_done", busy, 1'b0);
                check("frame_done_cleared", frame_done, 1'b0);
            end else if (junk && (c % 64 == 0)) begin
                check("in_ready_during_send", in_ready, 1'b0);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            in_valid = 1'b0;
            $display("FAIL frame_done_timeout: got none expected pulse");
        end
    endtask

    initial begin
        rstb     = 1'b0;
        in_valid = 1'b0;
        in_re    = 16'h0;
        in_im    = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_dv", tx_dv, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Ramp frame, back-to-back input.
        feed_frame(0, 1'b0);
        wait_frame(1'b0);

        // Throttled ramp, junk offered on in_valid while sending.
        feed_frame(0, 1'b1);
        wait_frame(1'b1);

        // Ramp interrupted by reset after byte 100.
        feed_frame(0, 1'b0);
        for (int c = 0; c < 5000 && dv_in_frame < 101; c++) begin
            @(posedge clk); #1;
        end
        check("reached_byte_100", (dv_in_frame >= 101), 1'b1);
        @(negedge clk); #2;
        rstb = 1'b0;
        #1;
        check("midrst_tx_dv", tx_dv, 1'b0);
        check("midrst_tx_byte", tx_byte, 8'h00);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        @(posedge clk); #1;

        // Fresh ramp, then back-to-back constant frame.
        feed_frame(0, 1'b0);
        wait_frame(1'b0);
        feed_frame(1, 1'b0);
        wait_frame(1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);
        check("frame_done_count", frames_seen, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
